// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : single-outstanding data-memory load/store unit
// Rev 1.0
// ============================================================================

package lsu_pkg;
  typedef enum logic [3:0] {
    LSU_NOP = 4'd0,
    LSU_LB  = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LW  = 4'd3,
    LSU_LBU = 4'd4,
    LSU_LHU = 4'd5,
    LSU_SB  = 4'd6,
    LSU_SH  = 4'd7,
    LSU_SW  = 4'd8
  } lsuCtrl_e;
endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              flush,
  input  lsuCtrl_e          lsu_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [3:0]        dmem_wstrb,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  lsuCtrl_e          op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;

  logic        is_store, is_half, is_word, bad_align, start, accept;
  logic [3:0]  fmt_strb;
  logic [31:0] fmt_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data;

  // start is gated by rst_n so stall/misaligned read zero while reset is held
  always_comb begin
    is_store  = lsu_ctrl inside {LSU_SB, LSU_SH, LSU_SW};
    is_half   = lsu_ctrl inside {LSU_LH, LSU_LHU, LSU_SH};
    is_word   = lsu_ctrl inside {LSU_LW, LSU_SW};
    bad_align = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    start     = rst_n & in_valid & ~flush & (lsu_ctrl != LSU_NOP) & (state_q == ST_IDLE);
    accept    = start & ~bad_align;

    fmt_strb  = 4'b0000;
    fmt_wdata = 32'h0000_0000;
    case (lsu_ctrl)
      LSU_SB: begin
        fmt_strb  = 4'b0001 << addr[1:0];
        fmt_wdata = {4{wdata[7:0]}};
      end
      LSU_SH: begin
        fmt_strb  = 4'b0011 << addr[1:0];
        fmt_wdata = {2{wdata[15:0]}};
      end
      LSU_SW: begin
        fmt_strb  = 4'b1111;
        fmt_wdata = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte  = dmem_rdata[{off_q, 3'b000} +: 8];
    rd_half  = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ext_data = dmem_rdata;
    case (op_q)
      LSU_LB:  ext_data = {{24{rd_byte[7]}}, rd_byte};
      LSU_LBU: ext_data = {24'h0, rd_byte};
      LSU_LH:  ext_data = {{16{rd_half[15]}}, rd_half};
      LSU_LHU: ext_data = {16'h0, rd_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          op_d    = lsu_ctrl;
          off_d   = addr[1:0];
          waddr_d = {addr[ADDR_W-1:2], 2'b00};
          we_d    = is_store;
          wstrb_d = fmt_strb;
          wdata_d = fmt_wdata;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (dmem_rsp_valid) begin
          state_d = ST_DONE;
          if (!we_q) load_data_d = ext_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= LSU_NOP;
      off_q       <= 2'b00;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign misaligned     = start & bad_align;
  assign stall          = accept | (state_q == ST_REQ) | (state_q == ST_RSP);
  assign done           = (state_q == ST_DONE);
  assign load_data      = load_data_q;
  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_addr      = waddr_q;
  assign dmem_we        = we_q;
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed bench with a transaction-level reference model
// Rev 1.0
// ============================================================================

module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  lsuCtrl_e    lsu_ctrl = LSU_NOP;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, misaligned;
  logic [31:0] load_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .flush          (flush),
    .lsu_ctrl       (lsu_ctrl),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .done           (done),
    .load_data      (load_data),
    .misaligned     (misaligned),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int unsigned acc_size(input lsuCtrl_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic bit is_st(input lsuCtrl_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  function automatic bit bad(input lsuCtrl_e op, input logic [31:0] a);
    return (a % acc_size(op)) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input lsuCtrl_e op, input logic [1:0] off);
    logic [3:0] s = 4'b0000;
    int unsigned sz = acc_size(op);
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + int'(sz)) s[i] = 1'b1;
    return is_st(op) ? s : 4'b0000;
  endfunction

  function automatic logic [31:0] exp_wd(input lsuCtrl_e op, input logic [31:0] wd);
    if (!is_st(op)) return 32'h0;
    case (acc_size(op))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_ld(input lsuCtrl_e op, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh = rd >> (8 * off);
    logic [31:0] v;
    case (op)
      LSU_LB:  begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      LSU_LBU: v = sh & 32'hFF;
      LSU_LH:  begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      LSU_LHU: v = sh & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- transaction model ----------------
  logic        m_req = 1'b0, m_rsp = 1'b0, m_done = 1'b0;
  logic [31:0] m_load = 32'h0, m_addr = 32'h0, m_wd = 32'h0;
  lsuCtrl_e    m_op = LSU_NOP;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= 1'b0; m_rsp <= 1'b0; m_done <= 1'b0;
      m_load <= 32'h0; m_addr <= 32'h0; m_wd <= 32'h0; m_op <= LSU_NOP;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_rsp) begin
      if (dmem_rsp_valid) begin
        m_rsp  <= 1'b0;
        m_done <= 1'b1;
        if (!is_st(m_op)) m_load <= exp_ld(m_op, m_addr[1:0], dmem_rdata);
      end
    end else if (m_req) begin
      if (dmem_req_ready) begin
        m_req <= 1'b0;
        m_rsp <= 1'b1;
      end
    end else if (in_valid && !flush && lsu_ctrl != LSU_NOP && !bad(lsu_ctrl, addr)) begin
      m_req <= 1'b1;
      m_op  <= lsu_ctrl;
      m_addr <= addr;
      m_wd  <= wdata;
    end
  end

  logic c_start;
  always @(negedge clk) begin
    c_start = rst_n && !m_req && !m_rsp && !m_done && in_valid && !flush && lsu_ctrl != LSU_NOP;
    chk("misaligned", misaligned, c_start && bad(lsu_ctrl, addr));
    chk("stall", stall, (c_start && !bad(lsu_ctrl, addr)) || m_req || m_rsp);
    chk("done", done, m_done);
    chk("load_data", load_data, m_load);
    chk("req_valid", dmem_req_valid, m_req);
    if (m_req) begin
      chk("dmem_addr", dmem_addr, m_addr & 32'hFFFF_FFFC);
      chk("dmem_we", dmem_we, is_st(m_op));
      chk("dmem_wstrb", dmem_wstrb, exp_strb(m_op, m_addr[1:0]));
      chk("dmem_wdata", dmem_wdata, exp_wd(m_op, m_wd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_stall, n_done;
  task automatic smp();
    #1;
    n_stall += int'(stall);
    n_done  += int'(done);
  endtask

  task automatic run_op(input lsuCtrl_e op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int rdy_dly, input int rsp_dly,
                        input bit flush_rsp,
                        output logic [31:0] o_load, output logic [31:0] o_addr,
                        output logic o_we, output logic [3:0] o_strb, output logic [31:0] o_wd);
    n_stall = 0; n_done = 0;
    in_valid = 1'b1; lsu_ctrl = op; addr = a; wdata = wd; dmem_rdata = rd;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; flush = 1'b0;
    smp();
    tick();
    for (int k = 0; k <= rdy_dly; k++) begin
      dmem_req_ready = (k == rdy_dly);
      smp();
      if (k == 0) begin
        o_addr = dmem_addr; o_we = dmem_we; o_strb = dmem_wstrb; o_wd = dmem_wdata;
      end
      tick();
    end
    dmem_req_ready = 1'b0;
    flush = flush_rsp;
    for (int k = 0; k <= rsp_dly; k++) begin
      dmem_rsp_valid = (k == rsp_dly);
      smp();
      tick();
    end
    dmem_rsp_valid = 1'b0; flush = 1'b0; in_valid = 1'b0; lsu_ctrl = LSU_NOP;
    smp();
    o_load = load_data;
    tick();
    smp();
  endtask

  logic [31:0] r_load, r_addr, r_wd;
  logic        r_we;
  logic [3:0]  r_strb;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_load", load_data, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_we", dmem_we, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_op(LSU_LB, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, r_load, r_addr, r_we, r_strb, r_wd);
    chk("lb_stall_cycles", n_stall, 3);
    chk("lb_done_cycles", n_done, 1);
    chk("lb_load", r_load, 32'hFFFF_FF80);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_wstrb", r_strb, 4'b0000);

    run_op(LSU_LHU, 32'h102, 32'h0, 32'hBEEF_0000, 0, 0, 0, r_load, r_addr, r_we, r_strb, r_wd);
    chk("lhu_load", r_load, 32'h0000_BEEF);
    run_op(LSU_LH, 32'h102, 32'h0, 32'hBEEF_0000, 0, 0, 0, r_load, r_addr, r_we, r_strb, r_wd);
    chk("lh_load", r_load, 32'hFFFF_BEEF);

    run_op(LSU_SB, 32'h201, 32'h1234_56A5, 32'h0, 0, 0, 0, r_load, r_addr, r_we, r_strb, r_wd);
    chk("sb_we", r_we, 1);
    chk("sb_wstrb", r_strb, 4'b0010);
    chk("sb_wdata", r_wd, 32'hA5A5_A5A5);
    chk("sb_load_kept", r_load, 32'hFFFF_BEEF);
    run_op(LSU_SH, 32'h202, 32'h1234_56A5, 32'h0, 0, 0, 0, r_load, r_addr, r_we, r_strb, r_wd);
    chk("sh_wstrb", r_strb, 4'b1100);
    chk("sh_wdata", r_wd, 32'h56A5_56A5);

    in_valid = 1'b1; lsu_ctrl = LSU_LW; addr = 32'h106;
    #1;
    chk("mis_flag", misaligned, 1);
    chk("mis_stall", stall, 0);
    tick();
    chk("mis_no_req", dmem_req_valid, 0);
    run_op(LSU_SW, 32'h200, 32'hCAFE_F00D, 32'h0, 0, 0, 0, r_load, r_addr, r_we, r_strb, r_wd);
    chk("sw_wstrb", r_strb, 4'b1111);
    chk("sw_wdata", r_wd, 32'hCAFE_F00D);
    chk("sw_stall_cycles", n_stall, 3);

    run_op(LSU_SW, 32'h204, 32'h0BAD_BEEF, 32'h0, 3, 2, 1, r_load, r_addr, r_we, r_strb, r_wd);
    chk("sw_slow_stall_cycles", n_stall, 8);
    chk("sw_slow_done_cycles", n_done, 1);
    chk("sw_slow_addr", r_addr, 32'h204);

    // reset in the middle of a load's response wait
    in_valid = 1'b1; lsu_ctrl = LSU_LW; addr = 32'h300; dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    chk("rsp_wait_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_req_valid", dmem_req_valid, 0);
    chk("midrst_addr", dmem_addr, 0);
    chk("midrst_load", load_data, 0);
    in_valid = 1'b0; lsu_ctrl = LSU_NOP;
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rsp_valid = 1'b1;
    tick();
    dmem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_rsp_done", done, 0);
      chk("late_rsp_load", load_data, 0);
      tick();
    end

    flush = 1'b1; in_valid = 1'b1; lsu_ctrl = LSU_LW; addr = 32'h100;
    #1;
    chk("flush_stall", stall, 0);
    tick();
    chk("flush_no_req", dmem_req_valid, 0);
    flush = 1'b0; in_valid = 1'b0; lsu_ctrl = LSU_NOP;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
